// File: rtl/dither_line_ctrl.sv
// rtl/dither_line_ctrl.sv - frame/line sequencer and per-channel error-diffusion quantizer for the VGA path
// Optional line-start error stagger enabled by defining DITHER_LINE_STAGGER_EN.
module dither_line_ctrl #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 4,
    parameter int LINE_W   = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic                           visible,
    input  logic [3*IN_BITS-1:0]           pix_in,
    input  logic [IN_BITS-OUT_BITS-1:0]    cfg_threshold,
    input  logic                           cfg_bypass,
    output logic [3*OUT_BITS-1:0]          pix_out,
    output logic                           out_valid,
    output logic [LINE_W-1:0]              line_count
);

    localparam int E  = IN_BITS - OUT_BITS;
    localparam int SW = IN_BITS + 2;

`ifdef DITHER_LINE_STAGGER_EN
    localparam bit STAGGER = 1'b1;
`else
    localparam bit STAGGER = 1'b0;
`endif

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        BLANK      = 2'd1,
        ACTIVE     = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    take_pix;
    logic [E-1:0]            thr_q;
    logic                    bypass_q;
    logic                    parity_q;
    logic [LINE_W-1:0]       line_count_q;
    logic signed [E:0]       line_start_err;
    logic [3*OUT_BITS-1:0]   pix_d;

    always_comb begin
        state_d  = state_q;
        take_pix = 1'b0;
        if (frame_start) begin
            state_d = BLANK;
        end else begin
            case (state_q)
                WAIT_FRAME: state_d = WAIT_FRAME;
                BLANK: begin
                    if (visible) begin
                        state_d  = ACTIVE;
                        take_pix = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (visible) begin
                        take_pix = 1'b1;
                    end else begin
                        state_d = BLANK;
                    end
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

    // Alternating lines (and frames) start with +half-LSB error to break vertical patterns.
    assign line_start_err = (STAGGER && (line_count_q[0] ^ parity_q)) ?
                            {2'b01, {(E-1){1'b0}}} : '0;

    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [IN_BITS-1:0]    px;
        logic signed [E:0]     err_q;
        logic signed [E:0]     err_d;
        logic signed [E:0]     err_in;
        logic signed [SW-1:0]  sum;
        logic [IN_BITS-1:0]    sat;
        logic [OUT_BITS-1:0]   msb;
        logic [E-1:0]          lsb;
        logic [OUT_BITS-1:0]   q;

        assign px     = pix_in[c*IN_BITS +: IN_BITS];
        assign err_in = (state_q == BLANK) ? line_start_err : err_q;
        assign sum    = {2'b00, px} + {{(SW-E-1){err_in[E]}}, err_in};

        always_comb begin
            sat = sum[IN_BITS-1:0];
            if (sum[SW-1]) begin
                sat = '0;
            end else if (sum[SW-2]) begin
                sat = '1;
            end
        end

        assign msb = sat[IN_BITS-1:E];
        assign lsb = sat[E-1:0];

        always_comb begin
            q     = msb;
            err_d = {1'b0, lsb};
            if (bypass_q) begin
                q     = px[IN_BITS-1:E];
                err_d = '0;
            end else if ((lsb >= thr_q) && (msb != '1)) begin
                q     = msb + OUT_BITS'(1);
                // lsb - 2^E in E+1 bit two's complement
                err_d = {1'b1, lsb};
            end
        end

        assign pix_d[c*OUT_BITS +: OUT_BITS] = q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                err_q <= '0;
            end else if (frame_start) begin
                err_q <= '0;
            end else if (take_pix) begin
                err_q <= err_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_FRAME;
            thr_q        <= {1'b1, {(E-1){1'b0}}};
            bypass_q     <= 1'b0;
            parity_q     <= 1'b0;
            line_count_q <= '0;
            pix_out      <= '0;
            out_valid    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= take_pix;
            pix_out   <= take_pix ? pix_d : '0;
            if (frame_start) begin
                thr_q        <= cfg_threshold;
                bypass_q     <= cfg_bypass;
                parity_q     <= ~parity_q;
                line_count_q <= '0;
            end else if ((state_q == ACTIVE) && !visible) begin
                line_count_q <= line_count_q + LINE_W'(1);
            end
        end
    end

    assign line_count = line_count_q;

endmodule

// File: doc/dither_line_ctrl.md
Name: dither_line_ctrl

Overview:
- Controller and sequencer for the 4-bit-per-channel error-diffusion dither stage in the VGA pixel path.
- Sits between the pixel source (8-bit R, G, B) and the DAC/VGA output.
- Tracks frame, line and visible state with an FSM and owns the per-channel signed error registers.
- Latches quantizer configuration at frame boundaries only; produces registered dithered pixels.

Parameters:
IN_BITS, 8, input bits per channel
OUT_BITS, 4, output bits per channel; E = IN_BITS-OUT_BITS (4)
LINE_W, 10, width of line counter

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous active-low reset (asserted when 0)
frame_start  input  1  one-cycle pulse at start of vertical blank
visible  input  1  high during active pixel region
pix_in  input  3*IN_BITS  {R,G,B} source pixel, valid when visible=1
cfg_threshold  input  E  rounding threshold, latched at frame_start
cfg_bypass  input  1  1 = plain truncation, latched at frame_start
pix_out  output  3*OUT_BITS  {R,G,B} dithered pixel
out_valid  output  1  pix_out corresponds to a visible pixel
line_count  output  LINE_W  visible lines completed in current frame

Behaviour:
- Reset (rst=0, async): pix_out=0, out_valid=0, line_count=0, all errors=0, thr_q=8, bypass_q=0, frame parity=0, state=WAIT_FRAME.
- States: WAIT_FRAME, BLANK, ACTIVE.
- WAIT_FRAME: ignore visible and pix_in; go to BLANK on frame_start.
- BLANK: go to ACTIVE when visible=1.
- ACTIVE: go to BLANK when visible=0; line_count increments on that transition (wraps at 2^LINE_W).
- frame_start in any state (priority over visible):
  - next state = BLANK; errors cleared; line_count=0; frame parity toggles.
  - thr_q<=cfg_threshold; bypass_q<=cfg_bypass.
  - frame_start coincident with visible=1: that pixel is dropped (out_valid=0 next cycle).
- Config inputs are ignored at all other times.
- Errors are cleared to their line-start value on every BLANK->ACTIVE transition, so there is no diffusion across lines.
- Per channel, each cycle the FSM is (or enters) ACTIVE with visible=1:
  - s = pix_in + err, computed signed with width IN_BITS+2, then clamped to [0, 2^IN_BITS-1].
  - M = s[IN_BITS-1:E], L = s[E-1:0].
  - bypass_q=1: out=pix_in[IN_BITS-1:E], err stays 0.
  - Else if L>=thr_q and M != max code: out=M+1, err=L-2^E (negative).
  - Else: out=M, err=L.
  - err is signed, E+1 bits, range [-2^E, 2^E-1].
- Latency 1: pix_out and out_valid are registered. out_valid(t+1)=visible(t) while in ACTIVE and no frame_start.
- When out_valid=0, pix_out=0.
- Channels are independent; R, G and B use identical logic with separate error registers.

Optional Feature:
- Macro: DITHER_LINE_STAGGER_EN
- Defined: the line-start error value is +2^(E-1) (i.e. +8) when line_count[0] XOR frame parity = 1, else 0. This breaks vertical error-diffusion patterning.
- Undefined: line-start error is always 0; frame parity is still kept but unused.

Test Plan:
1. Hold rst=0, toggle visible with pix_in=0xFFFFFF and no frame_start -> pix_out=0, out_valid=0 throughout; after release still 0 until first frame_start.
2. frame_start with cfg_threshold=8, cfg_bypass=0; visible line with R=0x18 -> R out sequence 2,1,2,1... starting one cycle after visible rises; out_valid high exactly for the line length.
3. Line with all channels 0xFF -> every output 0xFFF, no wrap to 0 (clamp path, err stays 15).
4. R=0x18 line ended after an odd pixel count (err=-8 pending); next line R=0x18 -> first output is 2 (error cleared at line start); line_count increments by 1 per line and resets to 0 on frame_start.
5. Set cfg_bypass=1 mid-frame -> no effect until next frame_start; after it, R=0x1F gives out=1 on every pixel.
6. With DITHER_LINE_STAGGER_EN, frame parity 0, line_count=1, R=0x18 -> outputs 2,2,1,2,1...; same stimulus without the macro -> 2,1,2,1...
